// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: FSM state encodings,
// ALU op-code constants and the default op-code width.
package alu_share_arbiter_pkg;

    localparam int OPW_DEF = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic [OPW_DEF-1:0] OP_ADD = 3'd0;
    localparam logic [OPW_DEF-1:0] OP_SUB = 3'd1;
    localparam logic [OPW_DEF-1:0] OP_AND = 3'd2;
    localparam logic [OPW_DEF-1:0] OP_OR  = 3'd3;
    localparam logic [OPW_DEF-1:0] OP_XOR = 3'd4;
    localparam logic [OPW_DEF-1:0] OP_SLL = 3'd5;
    localparam logic [OPW_DEF-1:0] OP_SRL = 3'd6;
    localparam logic [OPW_DEF-1:0] OP_SLT = 3'd7;

endpackage

// File: rtl/alu_share_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker.
//   req0, req1 : request lines
//   last       : requester served most recently (0 = R0, 1 = R1)
//   win        : chosen requester (valid when any = 1)
//   any        : at least one request present
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic win,
    output logic any
);

    // On a tie, pick whichever requester was not served last.
    assign win = (req0 && req1) ? ~last : req1;
    assign any = req0 | req1;

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters with round-robin arbitration.
// Drives the operand mux select and a registered op-code, waits ALU_LAT
// cycles, captures the ALU result and pulses done to the winner.
//   clk, rst_n      : clock, async active-low reset
//   req0/op0        : R0 request and op-code
//   req1/op1        : R1 request and op-code
//   alu_r           : ALU result input
//   sel, alu_op     : operand mux select, registered op-code to the ALU
//   gnt0, gnt1      : one-cycle grant pulses
//   result          : captured ALU result, held until next capture
//   done0, done1    : one-cycle result-ready pulses
//   busy            : high whenever the FSM is not IDLE
//
// state | meaning
// IDLE  | waiting for a request; sel/alu_op hold the last grant
// EXEC  | operation in flight, cnt counts down the ALU latency
// RESP  | result captured, done of the winner is high this cycle
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int OPW     = OPW_DEF,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [OPW-1:0]   op0,
    input  logic             req1,
    input  logic [OPW-1:0]   op1,
    input  logic [WIDTH-1:0] alu_r,
    output logic             sel,
    output logic [OPW-1:0]   alu_op,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] result,
    output logic             done0,
    output logic             done1,
    output logic             busy
);

    if (ALU_LAT < 1 || ALU_LAT > 15) begin : g_bad_lat
        $error("alu_share_arbiter: ALU_LAT must be in 1..15");
    end

    localparam logic [3:0] LAT_CNT = 4'(ALU_LAT);

    arb_state_t       state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic             last, last_nxt;
    logic             sel_nxt;
    logic [OPW-1:0]   op_nxt;
    logic [WIDTH-1:0] result_nxt;
    logic             gnt0_nxt, gnt1_nxt, done0_nxt, done1_nxt;
    logic             win, any;

    rr_pick2 u_pick (
        .req0 (req0),
        .req1 (req1),
        .last (last),
        .win  (win),
        .any  (any)
    );

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        last_nxt   = last;
        sel_nxt    = sel;
        op_nxt     = alu_op;
        result_nxt = result;
        gnt0_nxt   = 1'b0;
        gnt1_nxt   = 1'b0;
        done0_nxt  = 1'b0;
        done1_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (any) begin
                    sel_nxt   = win;
                    op_nxt    = win ? op1 : op0;
                    last_nxt  = win;
                    gnt0_nxt  = ~win;
                    gnt1_nxt  = win;
                    cnt_nxt   = LAT_CNT;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    result_nxt = alu_r;
                    // last already names the requester that owns this op
                    done0_nxt  = ~last;
                    done1_nxt  = last;
                    state_nxt  = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            last   <= 1'b1;
            sel    <= 1'b0;
            alu_op <= '0;
            result <= '0;
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            done0  <= 1'b0;
            done1  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            last   <= last_nxt;
            sel    <= sel_nxt;
            alu_op <= op_nxt;
            result <= result_nxt;
            gnt0   <= gnt0_nxt;
            gnt1   <= gnt1_nxt;
            done0  <= done0_nxt;
            done1  <= done1_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, req1;
    logic [2:0]  op0, op1;
    logic [31:0] alu_r;

    // dut a: ALU_LAT=1, dut b: ALU_LAT=4; shared inputs, separate outputs
    logic        a_sel, a_gnt0, a_gnt1, a_done0, a_done1, a_busy;
    logic [2:0]  a_alu_op;
    logic [31:0] a_result;
    logic        b_sel, b_gnt0, b_gnt1, b_done0, b_done1, b_busy;
    logic [2:0]  b_alu_op;
    logic [31:0] b_result;

    int total = 0;
    int bad   = 0;

    alu_share_arbiter #(.WIDTH(32), .OPW(3), .ALU_LAT(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .op0(op0), .req1(req1), .op1(op1), .alu_r(alu_r),
        .sel(a_sel), .alu_op(a_alu_op), .gnt0(a_gnt0), .gnt1(a_gnt1),
        .result(a_result), .done0(a_done0), .done1(a_done1), .busy(a_busy)
    );

    alu_share_arbiter #(.WIDTH(32), .OPW(3), .ALU_LAT(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .op0(op0), .req1(req1), .op1(op1), .alu_r(alu_r),
        .sel(b_sel), .alu_op(b_alu_op), .gnt0(b_gnt0), .gnt1(b_gnt1),
        .result(b_result), .done0(b_done0), .done1(b_done1), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        op0 = 3'd0; op1 = 3'd0; alu_r = 32'd0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Continuous checks on both instances.
    logic a_in_op, b_in_op, a_rec, b_rec;
    always @(negedge clk) begin
        if (!rst_n) begin
            a_in_op = 1'b0;
            b_in_op = 1'b0;
        end else begin
            total++;
            if ((a_gnt0 && a_gnt1) || (b_gnt0 && b_gnt1)) begin
                bad++;
                $display("FAIL gnt_exclusive a=%b%b b=%b%b required not both", a_gnt0, a_gnt1, b_gnt0, b_gnt1);
            end
            total++;
            if ((a_done0 && a_done1) || (b_done0 && b_done1)) begin
                bad++;
                $display("FAIL done_exclusive a=%b%b b=%b%b required not both", a_done0, a_done1, b_done0, b_done1);
            end
            if (a_gnt0 || a_gnt1) begin
                a_in_op = 1'b1;
                a_rec   = a_gnt1;
            end
            if (a_in_op) begin
                total++;
                if (a_sel !== a_rec) begin
                    bad++;
                    $display("FAIL a_sel_stable got=%b want=%b", a_sel, a_rec);
                end
                if (a_done0 || a_done1) a_in_op = 1'b0;
            end
            if (b_gnt0 || b_gnt1) begin
                b_in_op = 1'b1;
                b_rec   = b_gnt1;
            end
            if (b_in_op) begin
                total++;
                if (b_sel !== b_rec) begin
                    bad++;
                    $display("FAIL b_sel_stable got=%b want=%b", b_sel, b_rec);
                end
                if (b_done0 || b_done1) b_in_op = 1'b0;
            end
        end
    end

    task automatic test_reset();
        do_reset();
        total++;
        if ({a_sel, a_alu_op, a_gnt0, a_gnt1, a_done0, a_done1, a_busy, a_result} !== '0) begin
            bad++;
            $display("FAIL reset_a got sel=%b op=%0d g=%b%b d=%b%b busy=%b res=%h want all 0",
                     a_sel, a_alu_op, a_gnt0, a_gnt1, a_done0, a_done1, a_busy, a_result);
        end
        total++;
        if ({b_sel, b_alu_op, b_gnt0, b_gnt1, b_done0, b_done1, b_busy, b_result} !== '0) begin
            bad++;
            $display("FAIL reset_b got sel=%b op=%0d g=%b%b d=%b%b busy=%b res=%h want all 0",
                     b_sel, b_alu_op, b_gnt0, b_gnt1, b_done0, b_done1, b_busy, b_result);
        end
    endtask

    task automatic test_single();
        do_reset();
        op0 = alu_share_arbiter_pkg::OP_AND;
        alu_r = 32'h0000_00FF;
        req0 = 1'b1;
        step(); // cycle 1
        total++;
        if ({a_gnt0, a_gnt1, a_sel, a_alu_op, a_busy, a_done0} !== {1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL single_c1 got g=%b%b sel=%b op=%0d busy=%b d0=%b want g=10 sel=0 op=2 busy=1 d0=0",
                     a_gnt0, a_gnt1, a_sel, a_alu_op, a_busy, a_done0);
        end
        step(); // cycle 2
        total++;
        if ({a_done0, a_done1, a_gnt0, a_busy} !== 4'b1001 || a_result !== 32'h0000_00FF) begin
            bad++;
            $display("FAIL single_c2 got d=%b%b g0=%b busy=%b res=%h want d=10 g0=0 busy=1 res=000000ff",
                     a_done0, a_done1, a_gnt0, a_busy, a_result);
        end
        req0 = 1'b0;
        step(); // cycle 3
        total++;
        if ({a_busy, a_done0} !== 2'b00 || a_result !== 32'h0000_00FF) begin
            bad++;
            $display("FAIL single_c3 got busy=%b d0=%b res=%h want busy=0 d0=0 res=000000ff", a_busy, a_done0, a_result);
        end
        step(); // cycle 4
        total++;
        if ({a_gnt0, a_gnt1, a_busy} !== 3'b000 || a_alu_op !== 3'd2) begin
            bad++;
            $display("FAIL single_idle got g=%b%b busy=%b op=%0d want g=00 busy=0 op=2", a_gnt0, a_gnt1, a_busy, a_alu_op);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_op;
        do_reset();
        op0 = alu_share_arbiter_pkg::OP_SUB;
        op1 = alu_share_arbiter_pkg::OP_SLL;
        req0 = 1'b1;
        req1 = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            // grants every 3 cycles from cycle 1: R0, R1, R0, R1
            total++;
            if (a_gnt0 !== (c == 1 || c == 7) || a_gnt1 !== (c == 4 || c == 10)) begin
                bad++;
                $display("FAIL rr_gnt cycle=%0d got g=%b%b want g=%b%b", c, a_gnt0, a_gnt1,
                         (c == 1 || c == 7), (c == 4 || c == 10));
            end
            total++;
            if (a_done0 !== (c == 2 || c == 8) || a_done1 !== (c == 5 || c == 11)) begin
                bad++;
                $display("FAIL rr_done cycle=%0d got d=%b%b want d=%b%b", c, a_done0, a_done1,
                         (c == 2 || c == 8), (c == 5 || c == 11));
            end
            exp_op = (c >= 4 && c <= 6) || c >= 10 ? 3'd5 : 3'd1;
            total++;
            if (a_sel !== ((c >= 4 && c <= 6) || c >= 10) || a_alu_op !== exp_op) begin
                bad++;
                $display("FAIL rr_sel cycle=%0d got sel=%b op=%0d want sel=%b op=%0d", c, a_sel, a_alu_op,
                         ((c >= 4 && c <= 6) || c >= 10), exp_op);
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic test_lat4();
        do_reset();
        op1 = alu_share_arbiter_pkg::OP_SRL;
        alu_r = 32'hDEAD_BEEF;
        req1 = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            total++;
            if (b_gnt1 !== (c == 1) || b_gnt0 !== 1'b0) begin
                bad++;
                $display("FAIL lat4_gnt cycle=%0d got g=%b%b want g=0%b", c, b_gnt0, b_gnt1, (c == 1));
            end
            total++;
            if (b_done1 !== (c == 5) || b_done0 !== 1'b0) begin
                bad++;
                $display("FAIL lat4_done cycle=%0d got d=%b%b want d=0%b", c, b_done0, b_done1, (c == 5));
            end
            total++;
            if (b_sel !== 1'b1 || b_alu_op !== 3'd6 || b_busy !== (c <= 5)) begin
                bad++;
                $display("FAIL lat4_ctl cycle=%0d got sel=%b op=%0d busy=%b want sel=1 op=6 busy=%b",
                         c, b_sel, b_alu_op, b_busy, (c <= 5));
            end
            if (c == 5) begin
                total++;
                if (b_result !== 32'hDEAD_BEEF) begin
                    bad++;
                    $display("FAIL lat4_result got=%h want=deadbeef", b_result);
                end
                req1 = 1'b0;
            end
        end
    endtask

    task automatic test_reset_exec();
        do_reset();
        op0 = alu_share_arbiter_pkg::OP_OR;
        alu_r = 32'h1234_5678;
        req0 = 1'b1;
        step(); // cycle 1: gnt0
        step(); // cycle 2: EXEC
        total++;
        if (b_busy !== 1'b1 || b_alu_op !== 3'd3) begin
            bad++;
            $display("FAIL rexec_pre got busy=%b op=%0d want busy=1 op=3", b_busy, b_alu_op);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({b_sel, b_alu_op, b_gnt0, b_gnt1, b_done0, b_done1, b_busy, b_result} !== '0) begin
            bad++;
            $display("FAIL rexec_async got sel=%b op=%0d g=%b%b d=%b%b busy=%b res=%h want all 0",
                     b_sel, b_alu_op, b_gnt0, b_gnt1, b_done0, b_done1, b_busy, b_result);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            total++;
            if (b_done0 !== 1'b0 || b_busy !== 1'b0) begin
                bad++;
                $display("FAIL rexec_held cycle=%0d got d0=%b busy=%b want 0 0", c, b_done0, b_busy);
            end
        end
        rst_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            total++;
            if (b_gnt0 !== (c == 1) || b_done0 !== (c == 5)) begin
                bad++;
                $display("FAIL rexec_after cycle=%0d got g0=%b d0=%b want g0=%b d0=%b", c, b_gnt0, b_done0,
                         (c == 1), (c == 5));
            end
        end
        req0 = 1'b0;
    endtask

    task automatic test_drop();
        do_reset();
        op1 = alu_share_arbiter_pkg::OP_XOR;
        alu_r = 32'hA5A5_0F0F;
        req1 = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            step();
            if (c == 2) req1 = 1'b0;
            total++;
            if (b_gnt1 !== (c == 1) || b_gnt0 !== 1'b0 || b_done1 !== (c == 5) || b_busy !== (c <= 5)) begin
                bad++;
                $display("FAIL drop cycle=%0d got g=%b%b d1=%b busy=%b want g=0%b d1=%b busy=%b",
                         c, b_gnt0, b_gnt1, b_done1, b_busy, (c == 1), (c == 5), (c <= 5));
            end
        end
        total++;
        if (b_result !== 32'hA5A5_0F0F) begin
            bad++;
            $display("FAIL drop_result got=%h want=a5a50f0f", b_result);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        op0 = 3'd0; op1 = 3'd0; alu_r = 32'd0;
        test_reset();
        test_single();
        test_round_robin();
        test_lat4();
        test_reset_exec();
        test_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
